// File: rtl/ps2_key_event_tracker_pkg.sv
// Shared decoder states, PS/2 prefix bytes and event-word layout for the key event tracker.
package ps2_pkg;

    typedef enum logic [3:0] {
        IDLE    = 4'b0001,
        EXT     = 4'b0010,
        BRK     = 4'b0100,
        EXT_BRK = 4'b1000
    } dec_state_t;

    localparam logic [7:0] PS2_EXT = 8'hE0;
    localparam logic [7:0] PS2_BRK = 8'hF0;

    localparam int EVT_BRK_BIT = 9;
    localparam int EVT_EXT_BIT = 8;
    localparam int EVT_W       = 10;

    function automatic logic [EVT_W-1:0] make_evt(input logic brk, input logic ext,
                                                  input logic [7:0] code);
        logic [EVT_W-1:0] w;
        w = '0;
        w[EVT_BRK_BIT] = brk;
        w[EVT_EXT_BIT] = ext;
        w[7:0]         = code;
        return w;
    endfunction

endpackage

// File: rtl/ps2_evt_fifo.sv
// First-word fall-through event FIFO; the head word is held in a register so dout is a flop output.
module ps2_evt_fifo #(
    parameter int DEPTH = 8,
    parameter int W     = 10
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic [W-1:0]               din,
    input  logic                       pop,
    output logic                       valid,
    output logic [W-1:0]               dout,
    output logic [$clog2(DEPTH):0]     cnt,
    output logic                       full
);
    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr, rd_next;
    logic [AW:0]   cnt_next;
    logic          do_push, do_pop;

    assign valid   = (cnt != '0);
    assign full    = (cnt == (AW+1)'(DEPTH));
    assign do_pop  = pop && valid;
    assign do_push = push && (!full || do_pop);
    assign rd_next = rd_ptr + AW'(do_pop);

    always_comb begin
        cnt_next = cnt;
        if (do_push && !do_pop)
            cnt_next = cnt + 1'b1;
        else if (do_pop && !do_push)
            cnt_next = cnt - 1'b1;
    end

    always_ff @(posedge clk) begin
        if (do_push)
            mem[wr_ptr] <= din;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
            dout   <= '0;
        end else begin
            if (do_push)
                wr_ptr <= wr_ptr + 1'b1;
            rd_ptr <= rd_next;
            cnt    <= cnt_next;
            // the new head may be the word being written this very cycle
            if (cnt_next == '0)
                dout <= '0;
            else if (do_push && (rd_next == wr_ptr))
                dout <= din;
            else
                dout <= mem[rd_next];
        end
    end

endmodule

// File: rtl/ps2_key_event_tracker.sv
// PS/2 make/break decoder with held-key tracking, press counter and queued event output.
// Build option: define PS2_REPEAT_FILTER_EN to suppress typematic repeats of the held key.
//
// state   | meaning
// IDLE    | waiting for a code or prefix byte
// EXT     | E0 seen, next byte is extended make unless F0
// BRK     | F0 seen, next byte is a break code
// EXT_BRK | E0 F0 seen, next byte is an extended break code
module ps2_key_event_tracker
    import ps2_pkg::*;
#(
    parameter int FIFO_DEPTH = 8,
    parameter int CNT_W      = 8
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [7:0]                    ps2_data,
    input  logic                          ps2_valid,
    output logic                          evt_valid,
    output logic [9:0]                    evt_code,
    input  logic                          evt_ready,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_cnt,
    output logic                          overflow,
    input  logic                          ovf_clr,
    output logic                          key_held,
    output logic [8:0]                    cur_code,
    output logic [CNT_W-1:0]              press_cnt
);
    dec_state_t       state;
    logic             evt_fire, evt_brk, evt_ext, filtered, push, fifo_full, drop;
    logic [EVT_W-1:0] evt_word;
    logic [8:0]       key;

    always_comb begin
        evt_fire = 1'b0;
        evt_brk  = 1'b0;
        evt_ext  = 1'b0;
        if (ps2_valid) begin
            unique case (state)
                IDLE:    evt_fire = (ps2_data != PS2_EXT) && (ps2_data != PS2_BRK);
                EXT:     begin evt_fire = (ps2_data != PS2_BRK); evt_ext = 1'b1; end
                BRK:     begin evt_fire = 1'b1; evt_brk = 1'b1; end
                EXT_BRK: begin evt_fire = 1'b1; evt_brk = 1'b1; evt_ext = 1'b1; end
                default: evt_fire = 1'b0;
            endcase
        end
    end

    assign key      = {evt_ext, ps2_data};
    assign evt_word = make_evt(evt_brk, evt_ext, ps2_data);

`ifdef PS2_REPEAT_FILTER_EN
    assign filtered = evt_fire && !evt_brk && key_held && (key == cur_code);
`else
    assign filtered = 1'b0;
`endif

    assign push = evt_fire && !filtered;
    assign drop = push && fifo_full && !(evt_valid && evt_ready);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            key_held  <= 1'b0;
            cur_code  <= '0;
            press_cnt <= '0;
            overflow  <= 1'b0;
        end else begin
            if (ps2_valid) begin
                unique case (state)
                    IDLE: begin
                        if (ps2_data == PS2_EXT)      state <= EXT;
                        else if (ps2_data == PS2_BRK) state <= BRK;
                    end
                    EXT:     state <= (ps2_data == PS2_BRK) ? EXT_BRK : IDLE;
                    default: state <= IDLE;
                endcase
            end
            if (evt_fire && !evt_brk) begin
                key_held <= 1'b1;
                cur_code <= key;
                if (!filtered)
                    press_cnt <= press_cnt + 1'b1;
            end else if (evt_fire && evt_brk && (key == cur_code)) begin
                key_held <= 1'b0;
            end
            if (drop)
                overflow <= 1'b1;
            else if (ovf_clr)
                overflow <= 1'b0;
        end
    end

    ps2_evt_fifo #(.DEPTH(FIFO_DEPTH), .W(EVT_W)) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .din   (evt_word),
        .pop   (evt_ready),
        .valid (evt_valid),
        .dout  (evt_code),
        .cnt   (fifo_cnt),
        .full  (fifo_full)
    );

endmodule

// File: tb/tb_ps2_key_event_tracker.sv
// Directed bench for ps2_key_event_tracker: decode table plus overflow, wrap, reset and repeat sequences.
module tb_ps2_key_event_tracker;
    localparam int FIFO_DEPTH = 8;
    localparam int CNT_W      = 8;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  ps2_data;
    logic        ps2_valid;
    logic        evt_valid;
    logic [9:0]  evt_code;
    logic        evt_ready;
    logic [3:0]  fifo_cnt;
    logic        overflow;
    logic        ovf_clr;
    logic        key_held;
    logic [8:0]  cur_code;
    logic [7:0]  press_cnt;

    int n_checks = 0;
    int n_pass   = 0;

    ps2_key_event_tracker #(.FIFO_DEPTH(FIFO_DEPTH), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .ps2_data(ps2_data), .ps2_valid(ps2_valid),
        .evt_valid(evt_valid), .evt_code(evt_code), .evt_ready(evt_ready),
        .fifo_cnt(fifo_cnt), .overflow(overflow), .ovf_clr(ovf_clr),
        .key_held(key_held), .cur_code(cur_code), .press_cnt(press_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] b;
        logic       push;
        logic [9:0] code;
        logic       held;
        logic [8:0] cur;
        logic [7:0] cnt;
    } vec_t;

    vec_t tbl[15];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] b);
        ps2_data  = b;
        ps2_valid = 1'b1;
        step();
        ps2_valid = 1'b0;
    endtask

    task automatic do_reset();
        ps2_valid = 1'b0;
        ps2_data  = 8'h00;
        evt_ready = 1'b0;
        ovf_clr   = 1'b0;
        rst       = 1'b1;
        step();
        rst = 1'b0;
        step();
    endtask

    initial begin
        logic [9:0] drain_exp [8];
        logic [7:0] c;

        tbl[0]  = '{8'h1C, 1'b1, 10'h01C, 1'b1, 9'h01C, 8'd1};
        tbl[1]  = '{8'hF0, 1'b0, 10'h000, 1'b1, 9'h01C, 8'd1};
        tbl[2]  = '{8'h1C, 1'b1, 10'h21C, 1'b0, 9'h01C, 8'd1};
        tbl[3]  = '{8'hE0, 1'b0, 10'h000, 1'b0, 9'h01C, 8'd1};
        tbl[4]  = '{8'h75, 1'b1, 10'h175, 1'b1, 9'h175, 8'd2};
        tbl[5]  = '{8'hE0, 1'b0, 10'h000, 1'b1, 9'h175, 8'd2};
        tbl[6]  = '{8'hF0, 1'b0, 10'h000, 1'b1, 9'h175, 8'd2};
        tbl[7]  = '{8'h75, 1'b1, 10'h375, 1'b0, 9'h175, 8'd2};
        tbl[8]  = '{8'h1C, 1'b1, 10'h01C, 1'b1, 9'h01C, 8'd3};
        tbl[9]  = '{8'h32, 1'b1, 10'h032, 1'b1, 9'h032, 8'd4};
        tbl[10] = '{8'hF0, 1'b0, 10'h000, 1'b1, 9'h032, 8'd4};
        tbl[11] = '{8'h1C, 1'b1, 10'h21C, 1'b1, 9'h032, 8'd4};
        tbl[12] = '{8'hE1, 1'b1, 10'h0E1, 1'b1, 9'h0E1, 8'd5};
        tbl[13] = '{8'hF0, 1'b0, 10'h000, 1'b1, 9'h0E1, 8'd5};
        tbl[14] = '{8'hE1, 1'b1, 10'h2E1, 1'b0, 9'h0E1, 8'd5};

        do_reset();
        chk("rst_evt_valid", evt_valid, 0);
        chk("rst_evt_code",  evt_code,  0);
        chk("rst_fifo_cnt",  fifo_cnt,  0);
        chk("rst_overflow",  overflow,  0);
        chk("rst_key_held",  key_held,  0);
        chk("rst_cur_code",  cur_code,  0);
        chk("rst_press_cnt", press_cnt, 0);

        // decode table, consumer always ready so each event drains in one cycle
        evt_ready = 1'b1;
        for (int i = 0; i < 15; i++) begin
            send(tbl[i].b);
            chk($sformatf("tbl%0d_evt_valid", i), evt_valid, tbl[i].push);
            if (tbl[i].push) chk($sformatf("tbl%0d_evt_code", i), evt_code, tbl[i].code);
            chk($sformatf("tbl%0d_key_held", i), key_held, tbl[i].held);
            chk($sformatf("tbl%0d_cur_code", i), cur_code, tbl[i].cur);
            chk($sformatf("tbl%0d_press_cnt", i), press_cnt, tbl[i].cnt);
            step();
            chk($sformatf("tbl%0d_drained", i), evt_valid, 0);
        end

        // overflow, set-wins, clear, push+pop while full, then drain order
        do_reset();
        for (int i = 0; i < 9; i++) send(8'h10 + 8'(i));
        chk("ovf_fifo_cnt", fifo_cnt, 8);
        chk("ovf_overflow", overflow, 1);
        chk("ovf_head",     evt_code, 10'h010);
        chk("ovf_press",    press_cnt, 9);
        ovf_clr = 1'b1;
        send(8'h30);
        ovf_clr = 1'b0;
        chk("ovf_set_wins", overflow, 1);
        chk("ovf_press2",   press_cnt, 10);
        ovf_clr = 1'b1;
        step();
        ovf_clr = 1'b0;
        chk("ovf_cleared", overflow, 0);
        evt_ready = 1'b1;
        send(8'h20);
        chk("pp_fifo_cnt", fifo_cnt, 8);
        chk("pp_overflow", overflow, 0);
        chk("pp_head",     evt_code, 10'h011);
        for (int i = 0; i < 7; i++) drain_exp[i] = 10'h011 + 10'(i);
        drain_exp[7] = 10'h020;
        for (int i = 0; i < 8; i++) begin
            chk($sformatf("drain%0d_valid", i), evt_valid, 1);
            chk($sformatf("drain%0d_code", i),  evt_code,  drain_exp[i]);
            step();
        end
        chk("drain_empty_valid", evt_valid, 0);
        chk("drain_empty_cnt",   fifo_cnt,  0);
        step();
        chk("pop_empty_cnt", fifo_cnt, 0);

        // press counter wrap
        do_reset();
        evt_ready = 1'b1;
        for (int i = 0; i < 256; i++) begin
            c = 8'h10 + 8'(i % 16);
            send(c);
            send(8'hF0);
            send(c);
        end
        step();
        chk("wrap_press_cnt", press_cnt, 0);
        chk("wrap_key_held",  key_held,  0);
        chk("wrap_fifo_cnt",  fifo_cnt,  0);
        chk("wrap_overflow",  overflow,  0);

        // reset in the middle of an E0 F0 prefix
        send(8'hE0);
        send(8'hF0);
        rst = 1'b1;
        #3;
        rst = 1'b0;
        step();
        send(8'h1C);
        chk("midrst_valid", evt_valid, 1);
        chk("midrst_code",  evt_code,  10'h01C);
        chk("midrst_held",  key_held,  1);
        chk("midrst_cur",   cur_code,  9'h01C);
        chk("midrst_press", press_cnt, 1);

        // typematic repeat of the same key
        do_reset();
        send(8'h1C);
        send(8'h1C);
        send(8'h1C);
`ifdef PS2_REPEAT_FILTER_EN
        chk("rep_fifo_cnt",  fifo_cnt,  1);
        chk("rep_press_cnt", press_cnt, 1);
`else
        chk("rep_fifo_cnt",  fifo_cnt,  3);
        chk("rep_press_cnt", press_cnt, 3);
`endif
        chk("rep_key_held", key_held, 1);
        chk("rep_head",     evt_code, 10'h01C);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
